// File: rtl/count_step_checker_if.sv
// Fault-record channel from the step checker toward the system error logger.
// The checker drives the record and its valid flag; the logger drives ready.
interface count_step_checker_if;
  logic       flt_valid;
  logic       flt_ready;
  logic [2:0] flt_prev;
  logic [2:0] flt_cur;

  modport master (
    output flt_valid,
    output flt_prev,
    output flt_cur,
    input  flt_ready
  );

  modport slave (
    input  flt_valid,
    input  flt_prev,
    input  flt_cur,
    output flt_ready
  );
endinterface

// File: rtl/count_step_checker.sv
// Monitors the 3-bit up/down counter output and classifies every transition
// as legal (hold, +1, -1 mod 8, or a commanded jump) or illegal. Illegal steps
// produce a one-cycle pulse, bump a saturating tally, set a sticky flag and are
// offered to the error logger as a single-entry fault record.
module count_step_checker #(
  parameter int ERR_W         = 4,
  parameter bit ALLOW_REVERSE = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           count,
  input  logic                 cmd_valid,
  input  logic [2:0]           cmd_value,
  input  logic                 clear_fault,
  output logic                 fault,
  output logic                 err_pulse,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [2:0]           last_good,
  output logic                 flt_ovr,
  count_step_checker_if.master flt
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    UP,
    DOWN
  } state_t;

  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       prev_q;
  logic             fault_q, fault_d;
  logic             err_pulse_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_base;
  logic [2:0]       last_good_q, last_good_d;
  logic             flt_valid_q, flt_valid_d;
  logic [2:0]       flt_prev_q, flt_prev_d;
  logic [2:0]       flt_cur_q, flt_cur_d;
  logic             flt_ovr_q, flt_ovr_d;
  logic             legal, illegal;
  logic             handshake, load_rec, drop_rec;

  // Classify the current sample against the previous one and pick the next direction state
  always_comb begin
    state_d = state_q;
    legal   = 1'b1;
    illegal = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = SYNC;
      end
      default: begin
        if (cmd_valid) begin
          legal   = (count == cmd_value);
          state_d = SYNC;
        end else if (count == prev_q) begin
          legal = 1'b1;
        end else if (count == prev_q + 3'd1) begin
          legal   = !((state_q == DOWN) && !ALLOW_REVERSE);
          state_d = UP;
        end else if (count == prev_q - 3'd1) begin
          legal   = !((state_q == UP) && !ALLOW_REVERSE);
          state_d = DOWN;
        end else begin
          legal = 1'b0;
        end
        if (!legal) begin
          state_d = SYNC;
        end
        illegal = !legal;
      end
    endcase
  end

  // Derive tally, sticky flags and fault-record updates from the classification
  always_comb begin
    handshake   = flt_valid_q & flt.flt_ready;
    load_rec    = illegal & (!flt_valid_q | flt.flt_ready);
    drop_rec    = illegal & flt_valid_q & !flt.flt_ready;
    err_base    = clear_fault ? '0 : err_cnt_q;
    err_cnt_d   = err_base;
    if (illegal && !(&err_base)) begin
      err_cnt_d = err_base + ERR_ONE;
    end
    fault_d     = illegal | (fault_q & !clear_fault);
    last_good_d = illegal ? last_good_q : count;
    flt_ovr_d   = (clear_fault ? 1'b0 : flt_ovr_q) | drop_rec;
    flt_valid_d = flt_valid_q;
    flt_prev_d  = flt_prev_q;
    flt_cur_d   = flt_cur_q;
    if (load_rec) begin
      flt_valid_d = 1'b1;
      flt_prev_d  = prev_q;
      flt_cur_d   = count;
    end else if (handshake) begin
      flt_valid_d = 1'b0;
    end
  end

  // Register all state; reset returns the checker to IDLE with every output low
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= 3'd0;
      fault_q     <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
      last_good_q <= 3'd0;
      flt_valid_q <= 1'b0;
      flt_prev_q  <= 3'd0;
      flt_cur_q   <= 3'd0;
      flt_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= count;
      fault_q     <= fault_d;
      err_pulse_q <= illegal;
      err_cnt_q   <= err_cnt_d;
      last_good_q <= last_good_d;
      flt_valid_q <= flt_valid_d;
      flt_prev_q  <= flt_prev_d;
      flt_cur_q   <= flt_cur_d;
      flt_ovr_q   <= flt_ovr_d;
    end
  end

  assign fault         = fault_q;
  assign err_pulse     = err_pulse_q;
  assign err_cnt       = err_cnt_q;
  assign last_good     = last_good_q;
  assign flt_ovr       = flt_ovr_q;
  assign flt.flt_valid = flt_valid_q;
  assign flt.flt_prev  = flt_prev_q;
  assign flt.flt_cur   = flt_cur_q;

endmodule

// File: tb/tb_count_step_checker.sv
// Testbench for count_step_checker: two instances (reversal allowed / not
// allowed) share one stimulus stream and are compared every cycle against a
// behavioural model, with directed scenarios pinned by literal expectations.
module tb_count_step_checker;

  logic       clock = 1'b0;
  logic       rstIn = 1'b0;
  logic [2:0] cntIn = 3'd0;
  logic       cmdValidIn = 1'b0;
  logic [2:0] cmdValueIn = 3'd0;
  logic       clearIn = 1'b0;
  logic       readyIn = 1'b0;

  logic       faultA, pulseA, ovrA;
  logic [3:0] errA;
  logic [2:0] lastA;
  logic       faultB, pulseB, ovrB;
  logic [3:0] errB;
  logic [2:0] lastB;

  int checks = 0;
  int errors = 0;

  count_step_checker_if fA ();
  count_step_checker_if fB ();
  assign fA.flt_ready = readyIn;
  assign fB.flt_ready = readyIn;

  count_step_checker #(.ERR_W(4), .ALLOW_REVERSE(1'b1)) dutA (
    .clock(clock), .reset(rstIn), .count(cntIn), .cmd_valid(cmdValidIn),
    .cmd_value(cmdValueIn), .clear_fault(clearIn), .fault(faultA),
    .err_pulse(pulseA), .err_cnt(errA), .last_good(lastA), .flt_ovr(ovrA),
    .flt(fA)
  );

  count_step_checker #(.ERR_W(4), .ALLOW_REVERSE(1'b0)) dutB (
    .clock(clock), .reset(rstIn), .count(cntIn), .cmd_valid(cmdValidIn),
    .cmd_value(cmdValueIn), .clear_fault(clearIn), .fault(faultB),
    .err_pulse(pulseB), .err_cnt(errB), .last_good(lastB), .flt_ovr(ovrB),
    .flt(fB)
  );

  always #5 clock = ~clock;

  // Behavioural model state, index 0 = reversal allowed, 1 = reversal forbidden
  bit   modelOn = 1'b0;
  bit   mStarted[2];
  int   mDir[2];
  int   mPrev[2];
  int   mLast[2];
  bit   mFault[2];
  bit   mPulse[2];
  int   mErr[2];
  bit   mValid[2];
  int   mFPrev[2];
  int   mFCur[2];
  bit   mOvr[2];

  // Advance one model instance by one clock edge using the step rules
  task automatic modelStep(input int k, input bit allowRev);
    bit bad;
    int step;
    int newDir;
    bad = 1'b0;
    if (rstIn) begin
      mStarted[k] = 1'b0; mDir[k] = 0; mPrev[k] = 0; mLast[k] = 0;
      mFault[k] = 1'b0; mPulse[k] = 1'b0; mErr[k] = 0; mValid[k] = 1'b0;
      mFPrev[k] = 0; mFCur[k] = 0; mOvr[k] = 1'b0;
      return;
    end
    if (!mStarted[k]) begin
      mStarted[k] = 1'b1;
      mDir[k] = 0;
      mLast[k] = int'(cntIn);
    end else begin
      step = (int'(cntIn) - mPrev[k] + 8) % 8;
      newDir = mDir[k];
      if (cmdValidIn) begin
        bad = (cntIn != cmdValueIn);
        newDir = 0;
      end else if (step == 0) begin
        newDir = mDir[k];
      end else if (step == 1) begin
        bad = (mDir[k] == -1) && !allowRev;
        newDir = 1;
      end else if (step == 7) begin
        bad = (mDir[k] == 1) && !allowRev;
        newDir = -1;
      end else begin
        bad = 1'b1;
      end
      if (bad) newDir = 0;
      mDir[k] = newDir;
      if (!bad) mLast[k] = int'(cntIn);
    end
    if (clearIn) begin
      mFault[k] = 1'b0; mErr[k] = 0; mOvr[k] = 1'b0;
    end
    if (bad) begin
      mFault[k] = 1'b1;
      if (mErr[k] < 15) mErr[k] = mErr[k] + 1;
      if (!mValid[k] || readyIn) begin
        mValid[k] = 1'b1; mFPrev[k] = mPrev[k]; mFCur[k] = int'(cntIn);
      end else begin
        mOvr[k] = 1'b1;
      end
    end else if (mValid[k] && readyIn) begin
      mValid[k] = 1'b0;
    end
    mPulse[k] = bad;
    mPrev[k] = int'(cntIn);
  endtask

  // Update the model on every rising edge
  always @(posedge clock) begin
    modelStep(0, 1'b1);
    modelStep(1, 1'b0);
    if (rstIn) modelOn = 1'b1;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareInst(input int k, input logic f, input logic p,
                             input logic [3:0] e, input logic [2:0] lg,
                             input logic v, input logic [2:0] fp,
                             input logic [2:0] fc, input logic o);
    string s;
    s = (k == 0) ? "A" : "B";
    checkOutput({"fault", s}, int'(f), int'(mFault[k]));
    checkOutput({"err_pulse", s}, int'(p), int'(mPulse[k]));
    checkOutput({"err_cnt", s}, int'(e), mErr[k]);
    checkOutput({"last_good", s}, int'(lg), mLast[k]);
    checkOutput({"flt_valid", s}, int'(v), int'(mValid[k]));
    checkOutput({"flt_prev", s}, int'(fp), mFPrev[k]);
    checkOutput({"flt_cur", s}, int'(fc), mFCur[k]);
    checkOutput({"flt_ovr", s}, int'(o), int'(mOvr[k]));
  endtask

  // Compare both instances against the model on every falling edge
  always @(negedge clock) begin
    if (modelOn) begin
      compareInst(0, faultA, pulseA, errA, lastA, fA.flt_valid, fA.flt_prev, fA.flt_cur, ovrA);
      compareInst(1, faultB, pulseB, errB, lastB, fB.flt_valid, fB.flt_prev, fB.flt_cur, ovrB);
    end
  end

  task automatic applyStimulus(input bit rst, input logic [2:0] c, input bit cv,
                               input logic [2:0] cval, input bit clr, input bit rdy);
    rstIn = rst; cntIn = c; cmdValidIn = cv; cmdValueIn = cval;
    clearIn = clr; readyIn = rdy;
    @(negedge clock);
  endtask

  initial begin
    logic [2:0] cur;
    int r;
    bit cv;
    logic [2:0] cval;

    // Full ramp with wrap, no faults expected
    applyStimulus(1, 0, 0, 0, 0, 1);
    checkOutput("rst_fault", int'(faultA), 0);
    checkOutput("rst_err_cnt", int'(errA), 0);
    checkOutput("rst_flt_valid", int'(fA.flt_valid), 0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 3'(i % 8), 0, 0, 0, 1);
    checkOutput("ramp_fault", int'(faultB), 0);
    checkOutput("ramp_last_good", int'(lastA), 0);
    checkOutput("ramp_err_cnt", int'(errB), 0);

    // Jump 2 -> 5 then re-sync on 6
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0, 0);
    applyStimulus(0, 5, 0, 0, 0, 0);
    checkOutput("jump_pulse", int'(pulseA), 1);
    checkOutput("jump_err_cnt", int'(errA), 1);
    checkOutput("jump_flt_prev", int'(fA.flt_prev), 2);
    checkOutput("jump_flt_cur", int'(fA.flt_cur), 5);
    checkOutput("jump_last_good", int'(lastA), 2);
    applyStimulus(0, 6, 0, 0, 0, 0);
    checkOutput("resync_pulse", int'(pulseA), 0);
    checkOutput("resync_last_good", int'(lastA), 6);

    // Commanded reset: matching and mismatching value
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 3, 0, 0, 0, 1);
    applyStimulus(0, 0, 1, 0, 0, 1);
    checkOutput("cmd_ok_fault", int'(faultA), 0);
    checkOutput("cmd_ok_last_good", int'(lastA), 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    applyStimulus(0, 3, 0, 0, 0, 1);
    applyStimulus(0, 4, 1, 0, 0, 1);
    checkOutput("cmd_bad_fault", int'(faultA), 1);
    checkOutput("cmd_bad_flt_prev", int'(fA.flt_prev), 3);
    checkOutput("cmd_bad_flt_cur", int'(fA.flt_cur), 4);

    // Direction reversal 2,3,4,3
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 0);
    applyStimulus(0, 4, 0, 0, 0, 0);
    applyStimulus(0, 3, 0, 0, 0, 0);
    checkOutput("rev_forbid_fault", int'(faultB), 1);
    checkOutput("rev_forbid_flt_prev", int'(fB.flt_prev), 4);
    checkOutput("rev_forbid_flt_cur", int'(fB.flt_cur), 3);
    checkOutput("rev_allow_fault", int'(faultA), 0);
    checkOutput("rev_allow_last_good", int'(lastA), 3);

    // Overrun while the record is pending, then drain
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 6, 0, 0, 0, 0);
    applyStimulus(0, 2, 0, 0, 0, 0);
    checkOutput("ovr_flt_prev", int'(fA.flt_prev), 1);
    checkOutput("ovr_flt_cur", int'(fA.flt_cur), 6);
    checkOutput("ovr_flag", int'(ovrA), 1);
    checkOutput("ovr_err_cnt", int'(errA), 2);
    applyStimulus(0, 2, 0, 0, 0, 1);
    checkOutput("drain_flt_valid", int'(fA.flt_valid), 0);

    // Saturation, clear and reset with a pending record
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) applyStimulus(0, (i % 2 == 0) ? 3'd4 : 3'd0, 0, 0, 0, 0);
    checkOutput("sat_err_cnt", int'(errA), 15);
    applyStimulus(0, 4, 0, 0, 1, 0);
    checkOutput("clr_err_cnt", int'(errA), 0);
    checkOutput("clr_fault", int'(faultA), 0);
    checkOutput("clr_ovr", int'(ovrA), 0);
    checkOutput("clr_keeps_valid", int'(fA.flt_valid), 1);
    applyStimulus(1, 4, 0, 0, 0, 0);
    checkOutput("rst2_flt_valid", int'(fA.flt_valid), 0);
    checkOutput("rst2_flt_cur", int'(fA.flt_cur), 0);
    checkOutput("rst2_last_good", int'(lastA), 0);

    // Randomized traffic checked by the model every cycle
    cur = 3'd0;
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30) cur = cur;
      else if (r < 55) cur = cur + 3'd1;
      else if (r < 80) cur = cur - 3'd1;
      else cur = 3'($urandom_range(0, 7));
      cv = ($urandom_range(0, 9) == 0);
      cval = ($urandom_range(0, 1) == 1) ? cur : 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 59) == 0), cur, cv, cval,
                    ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_step_checker.md
Name: count_step_checker

Overview:
Downstream monitor for the 3-bit fault-tolerant up/down counter output. Samples the counter's count every clock and classifies each transition as legal (hold, +1, −1 mod 8, or a commanded reset/preset jump) or illegal. Illegal steps raise a one-cycle pulse, bump a saturating error tally, set a sticky flag, and are reported through a single-entry valid/ready fault record toward the system error logger.

Parameters:
ERR_W, 4, width of the saturating error counter
ALLOW_REVERSE, 1, 1 = direction change between consecutive steps is legal; 0 = reversal is a fault

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clears all state on a rising edge where high
count  input  3  counter output under observation
cmd_valid  input  1  counter received a reset/preset command that takes effect at this edge
cmd_value  input  3  value the count must take when cmd_valid=1 (0 for reset)
clear_fault  input  1  clears sticky fault and err_cnt
fault  output  1  sticky: at least one illegal step since reset/clear
err_pulse  output  1  high for exactly one cycle per detected illegal step
err_cnt  output  ERR_W  number of illegal steps, saturates at all-ones
last_good  output  3  most recent sample accepted as legal
flt_valid  output  1  fault record pending
flt_ready  input  1  consumer accepts record when flt_valid & flt_ready
flt_prev  output  3  reference value before the illegal step
flt_cur  output  3  illegal value observed
flt_ovr  output  1  sticky: a fault was dropped because the record was still pending

Behaviour:
- Reset (clock edge with reset=1): state=IDLE; fault=0, err_pulse=0, err_cnt=0, last_good=0, flt_valid=0, flt_prev=0, flt_cur=0, flt_ovr=0. reset overrides every other input.
- All outputs registered; a fault in the sample taken at edge N is visible after edge N (err_pulse high during cycle N→N+1).
- prev = internal register holding the last sample; cur = count at the current edge.
- States: IDLE, SYNC (one sample, no direction), UP, DOWN.
  - IDLE: capture prev=cur, last_good=cur, go SYNC. No check.
  - SYNC/UP/DOWN: evaluate cur against prev, first matching rule wins:
    1. cmd_valid=1: legal iff cur==cmd_value; either way next state=SYNC.
    2. cur==prev: legal, state unchanged.
    3. cur==prev+1 mod 8 (7→0 legal): legal unless state=DOWN and ALLOW_REVERSE=0; next=UP.
    4. cur==prev−1 mod 8 (0→7 legal): legal unless state=UP and ALLOW_REVERSE=0; next=DOWN.
    5. Anything else: illegal.
  - Legal: last_good=cur.
  - Illegal: err_pulse=1, fault=1, err_cnt+1 (hold at 2^ERR_W−1), next=SYNC (re-acquire), last_good unchanged.
  - prev=cur after every evaluated edge, legal or not.
- Fault record: on illegal step, if flt_valid=0, or flt_valid=1 with flt_ready=1 this edge: load flt_prev=prev, flt_cur=cur, flt_valid=1. If flt_valid=1 and flt_ready=0: record kept, new one dropped, flt_ovr=1. If flt_valid & flt_ready with no new fault: flt_valid=0. flt_prev/flt_cur stable while flt_valid=1.
- clear_fault=1: fault=0, err_cnt=0, flt_ovr=0. An illegal step at the same edge wins: fault=1, err_cnt=1. clear_fault does not touch flt_valid or the state machine.
- Reset mid-record: record discarded, flt_valid=0 on the next cycle.

Test Plan:
- reset 1 cycle, then count 0,1,2,3,4,5,6,7,0 -> no err_pulse, fault=0, last_good=0, final state UP.
- ramp up 0,1,2 then jump to 5 -> err_pulse one cycle, fault=1, err_cnt=1, flt_valid=1, flt_prev=2, flt_cur=5, last_good=2; then 6 accepted (re-sync), last_good=6.
- count 3 with cmd_valid=1, cmd_value=0, count→0 -> legal; repeat with count→4 -> fault, flt_prev=3, flt_cur=4.
- ALLOW_REVERSE=0: 2,3,4,3 -> fault on 4→3, flt_prev=4, flt_cur=3; ALLOW_REVERSE=1, same sequence -> no fault, state DOWN.
- flt_ready=0, two illegal steps (1→6, 6→2) -> record keeps 1/6, flt_ovr=1, err_cnt=2; flt_ready=1 -> flt_valid drops next cycle.
- ERR_W=4, 17 illegal steps -> err_cnt=15 held; clear_fault -> err_cnt=0, fault=0, flt_ovr=0; reset asserted with flt_valid=1 -> all outputs 0.
